// File: rtl/out_pixel_packer.sv
// Output pixel packer: merges the byte-wide pixel write stream of the bilinear
// core into 32-bit little-endian words with byte enables, buffers them in a
// first-word-fall-through FIFO and hands them to the memory port over
// valid/ready. End of frame flushes the partial word, drains, and pulses flushed.
module out_pixel_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             pix_valid,
    input  logic [31:0]      pix_addr,
    input  logic [7:0]       pix_data,
    input  logic             frame_done,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             busy,
    output logic             flushed,
    output logic             overflow,
    output logic [CNT_W-1:0] words_written
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Place one byte into its lane of a word.
    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r = word;
        endcase
        return r;
    endfunction

    // One-hot byte enable for a lane.
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        logic [3:0] r;
        case (lane)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            2'd3:    r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              fd_q;
    logic              acc_valid_q, acc_valid_d;
    logic [29:0]       acc_word_q, acc_word_d;
    logic [31:0]       acc_data_q, acc_data_d;
    logic [3:0]        acc_be_q, acc_be_d;
    logic              flushed_q, flushed_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  words_q;

    logic [29:0]       fifo_addr_q [FIFO_DEPTH];
    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [3:0]        fifo_be_q   [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;

    logic fd_rise_s, accept_s, same_word_s, push_s, we_s, pop_s, full_s, empty_s;

    assign fd_rise_s   = frame_done & ~fd_q;
    assign accept_s    = pix_valid & (state_q != S_DRAIN);
    assign same_word_s = (acc_word_q == pix_addr[31:2]);
    assign empty_s     = (count_q == {(AW+1){1'b0}});
    assign full_s      = (count_q == DEPTH_C);
    assign pop_s       = ~empty_s & mem_ready;
    // A push into a full FIFO is only lost if nothing leaves in the same cycle.
    assign we_s        = push_s & (~full_s | pop_s);

    // Next-state for the FSM, accumulator, flush pulse and sticky overflow.
    always_comb begin
        state_d     = state_q;
        acc_valid_d = acc_valid_q;
        acc_word_d  = acc_word_q;
        acc_data_d  = acc_data_q;
        acc_be_d    = acc_be_q;
        push_s      = 1'b0;
        flushed_d   = 1'b0;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (pix_valid) begin
                    state_d = fd_rise_s ? S_DRAIN : S_RUN;
                end else if (fd_rise_s) begin
                    flushed_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (fd_rise_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (!acc_valid_q && empty_s) begin
                    flushed_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept_s) begin
            if (acc_valid_q && same_word_s) begin
                acc_data_d = merge_byte(acc_data_q, pix_addr[1:0], pix_data);
                acc_be_d   = acc_be_q | lane_be(pix_addr[1:0]);
            end else begin
                // Different word (or empty accumulator): retire the old word, start a new one.
                push_s      = acc_valid_q;
                acc_valid_d = 1'b1;
                acc_word_d  = pix_addr[31:2];
                acc_data_d  = merge_byte(32'h0000_0000, pix_addr[1:0], pix_data);
                acc_be_d    = lane_be(pix_addr[1:0]);
            end
        end else if (acc_valid_q && ((acc_be_q == 4'hF) || (state_q == S_DRAIN))) begin
            push_s      = 1'b1;
            acc_valid_d = 1'b0;
        end else begin
            acc_valid_d = acc_valid_q;
        end

        if ((pix_valid && (state_q == S_DRAIN)) || (push_s && full_s && !pop_s)) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control registers: FSM, edge detector, accumulator, flags, counters, pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fd_q        <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_word_q  <= 30'd0;
            acc_data_q  <= 32'd0;
            acc_be_q    <= 4'd0;
            flushed_q   <= 1'b0;
            overflow_q  <= 1'b0;
            words_q     <= {CNT_W{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {(AW+1){1'b0}};
        end else if (clear) begin
            state_q     <= S_IDLE;
            fd_q        <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_word_q  <= 30'd0;
            acc_data_q  <= 32'd0;
            acc_be_q    <= 4'd0;
            flushed_q   <= 1'b0;
            overflow_q  <= 1'b0;
            words_q     <= {CNT_W{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {(AW+1){1'b0}};
        end else begin
            state_q     <= state_d;
            fd_q        <= frame_done;
            acc_valid_q <= acc_valid_d;
            acc_word_q  <= acc_word_d;
            acc_data_q  <= acc_data_d;
            acc_be_q    <= acc_be_d;
            flushed_q   <= flushed_d;
            overflow_q  <= overflow_d;
            if (we_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
                words_q  <= words_q + CNT_W'(1'b1);
            end
            case ({we_s, pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1'b1);
                2'b01:   count_q <= count_q - (AW+1)'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only observable through a valid head entry.
    always_ff @(posedge clk) begin
        if (we_s) begin
            fifo_addr_q[wr_ptr_q] <= acc_word_q;
            fifo_data_q[wr_ptr_q] <= acc_data_q;
            fifo_be_q[wr_ptr_q]   <= acc_be_q;
        end
    end

    assign mem_valid     = ~empty_s;
    assign mem_addr      = empty_s ? 32'd0 : {fifo_addr_q[rd_ptr_q], 2'b00};
    assign mem_wdata     = empty_s ? 32'd0 : fifo_data_q[rd_ptr_q];
    assign mem_be        = empty_s ? 4'd0  : fifo_be_q[rd_ptr_q];
    assign busy          = (state_q != S_IDLE) | ~empty_s;
    assign flushed       = flushed_q;
    assign overflow      = overflow_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_out_pixel_packer.sv
// Directed testbench for out_pixel_packer: contiguous frame, partial tail,
// backpressure overflow, address jump, pixel coincident with frame_done, and
// asynchronous reset mid-frame.
module tb_out_pixel_packer;

    logic        clk = 1'b0;
    logic        rst_n, clear, pix_valid, frame_done, mem_ready;
    logic [31:0] pix_addr;
    logic [7:0]  pix_data;
    logic        mem_valid, busy, flushed, overflow;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [15:0] words_written;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int flush_cnt = 0, flush_qsize = 0;
    logic [67:0] q [$];   // {addr, data, be} of each completed handshake

    out_pixel_packer #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_data(pix_data),
        .frame_done(frame_done),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .busy(busy), .flushed(flushed), .overflow(overflow),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Record handshakes and flush pulses midway between active edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_valid && mem_ready) q.push_back({mem_addr, mem_wdata, mem_be});
            if (flushed) begin
                flush_cnt   = flush_cnt + 1;
                flush_qsize = q.size();
            end
        end
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [31:0] a, input logic [7:0] d);
        pix_valid = 1'b1;
        pix_addr  = a;
        pix_data  = d;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic wait_flush(input string tag, input int budget);
        int  start;
        logic seen;
        start = flush_cnt;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (flush_cnt != start) seen = 1'b1;
        end
        chk(tag, 72'(seen), 72'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        q.delete();
        flush_cnt = 0;
    endtask

    initial begin
        logic [7:0] b;
        rst_n = 1'b0; clear = 1'b0; pix_valid = 1'b0; pix_addr = 32'd0;
        pix_data = 8'd0; frame_done = 1'b0; mem_ready = 1'b1;

        // ---- reset state
        #12;
        chk("rst outs", 72'({mem_valid, busy, flushed, overflow, words_written}), 72'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst after", 72'({mem_valid, busy, flushed, overflow, mem_addr, mem_be, words_written}), 72'd0);

        // ---- contiguous frame, plus lane-3 latency
        for (int i = 0; i < 8; i++) begin
            pix(32'(i), 8'(8'h10 + i));
            if (i == 3) chk("lat pre", 72'(mem_valid), 72'd0);
            tick();
            if (i == 3) chk("lat post", 72'({mem_valid, mem_addr, mem_be}), 72'({1'b1, 32'h0, 4'hF}));
        end
        frame_done = 1'b1;
        wait_flush("t1 flushed", 40);
        repeat (5) tick();
        chk("t1 no retrigger", 72'(flush_cnt), 72'd1);
        frame_done = 1'b0;
        tick();
        chk("t1 nwords", 72'(q.size()), 72'd2);
        chk("t1 w0", 72'(q[0]), 72'({32'h0, 32'h1312_1110, 4'hF}));
        chk("t1 w1", 72'(q[1]), 72'({32'h4, 32'h1716_1514, 4'hF}));
        chk("t1 words_written", 72'(words_written), 72'd2);
        chk("t1 idle", 72'({busy, overflow}), 72'd0);

        // ---- partial tail
        do_clear();
        chk("clear words", 72'(words_written), 72'd0);
        for (int i = 0; i < 6; i++) begin
            pix(32'(i), 8'(8'h10 + i));
            tick();
        end
        frame_done = 1'b1;
        wait_flush("t2 flushed", 40);
        frame_done = 1'b0;
        tick();
        chk("t2 nwords", 72'(q.size()), 72'd2);
        chk("t2 qsize at flush", 72'(flush_qsize), 72'd2);
        chk("t2 w1 addr", 72'(q[1][67:36]), 72'h4);
        chk("t2 w1 data lo", 72'(q[1][19:4]), 72'h1514);
        chk("t2 w1 be", 72'(q[1][3:0]), 72'h3);
        chk("t2 flush count", 72'(flush_cnt), 72'd1);

        // ---- backpressure: 40 pixels, 10 words into an 8-deep FIFO
        do_clear();
        mem_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pix(32'(i), 8'(8'h40 + i));
            if (i == 20 || i == 39)
                chk($sformatf("t3 hold %0d", i), 72'({mem_valid, mem_addr, mem_wdata, mem_be}),
                    72'({1'b1, 32'h0, 32'h4342_4140, 4'hF}));
        end
        tick();
        tick();
        chk("t3 overflow", 72'({overflow, mem_valid, busy}), 72'b111);
        chk("t3 hold end", 72'({mem_addr, mem_wdata}), 72'({32'h0, 32'h4342_4140}));
        mem_ready  = 1'b1;
        frame_done = 1'b1;
        wait_flush("t3 flushed", 100);
        frame_done = 1'b0;
        tick();
        chk("t3 nwords", 72'(q.size()), 72'd8);
        for (int k = 0; k < 8; k++) begin
            b = 8'(8'h40 + 4 * k);
            chk($sformatf("t3 w%0d", k), 72'(q[k]),
                72'({32'(4 * k), b + 8'd3, b + 8'd2, b + 8'd1, b, 4'hF}));
        end
        chk("t3 words_written", 72'(words_written), 72'd8);
        chk("t3 overflow sticky", 72'(overflow), 72'd1);
        do_clear();
        chk("t3 clear overflow", 72'(overflow), 72'd0);

        // ---- address jump
        pix(32'd0, 8'hB0);
        tick();
        pix(32'd1, 8'hB1);
        tick();
        chk("t4 no push yet", 72'(mem_valid), 72'd0);
        pix(32'd9, 8'h99);
        chk("t4 w0 pushed", 72'({mem_valid, mem_addr, mem_be}), 72'({1'b1, 32'h0, 4'h3}));
        chk("t4 w0 data", 72'(mem_wdata[15:0]), 72'hB1B0);
        frame_done = 1'b1;
        wait_flush("t4 flushed", 40);
        frame_done = 1'b0;
        tick();
        chk("t4 nwords", 72'(q.size()), 72'd2);
        chk("t4 w1 addr", 72'(q[1][67:36]), 72'h8);
        chk("t4 w1 be", 72'(q[1][3:0]), 72'h2);
        chk("t4 w1 byte", 72'(q[1][19:12]), 72'h99);

        // ---- pixel coincident with frame_done rise
        do_clear();
        for (int i = 0; i < 3; i++) begin
            pix(32'(i), 8'(8'hA0 + i));
            tick();
        end
        frame_done = 1'b1;
        pix(32'd3, 8'hA3);
        wait_flush("t5 flushed", 40);
        frame_done = 1'b0;
        tick();
        chk("t5 nwords", 72'(q.size()), 72'd1);
        chk("t5 w0", 72'(q[0]), 72'({32'h0, 32'hA3A2_A1A0, 4'hF}));
        chk("t5 qsize at flush", 72'(flush_qsize), 72'd1);

        // ---- asynchronous reset mid-frame with 3 words queued
        flush_cnt = 0;
        mem_ready = 1'b0;
        for (int i = 0; i < 12; i++) pix(32'(i), 8'(8'hE0 + i));
        tick();
        chk("t6 queued", 72'({mem_valid, busy, words_written}), 72'({1'b1, 1'b1, 16'd1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async", 72'({mem_valid, busy, words_written}), 72'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("t6 after", 72'({mem_valid, overflow, flushed, words_written}), 72'd0);
        chk("t6 no flush", 72'(flush_cnt), 72'd0);
        q.delete();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix(32'(i), 8'(8'hC0 + i));
            tick();
        end
        frame_done = 1'b1;
        wait_flush("t6 flushed", 40);
        frame_done = 1'b0;
        tick();
        chk("t6 nwords", 72'(q.size()), 72'd1);
        chk("t6 w0", 72'(q[0]), 72'({32'h0, 32'hC3C2_C1C0, 4'hF}));
        chk("t6 words_written", 72'(words_written), 72'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
